// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
// Combinational constants only; no latency and no backpressure of its own.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF   = 8;
  localparam int DATA_W_DEF   = 8;
  localparam int MAX_WAIT_DEF = 4;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_EXT = 1'b1;

  typedef enum logic {
    S_OPEN   = 1'b0,
    S_LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU port, external port and data_memory signals around the arbiter.
// master = requesters plus memory, slave = the arbiter itself.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_stall;

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_lock;
  logic              ext_gnt;
  logic [DATA_W-1:0] ext_rdata;
  logic              ext_rvalid;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall,
    output ext_req, ext_we, ext_addr, ext_wdata, ext_lock,
    input  ext_gnt, ext_rdata, ext_rvalid,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall,
    input  ext_req, ext_we, ext_addr, ext_wdata, ext_lock,
    output ext_gnt, ext_rdata, ext_rvalid,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating wait counter with clear; at_max flags MAX_WAIT consecutive losses.
// Counts on the clock edge; clear has priority over increment.
module starve_counter #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] cnt;

  assign at_max = (cnt == CNT_W'(MAX_WAIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU fixed priority, external port starvation-bounded; DMEM_ARB_LOCK_EN adds ext bus lock.
// Grant and mux are combinational (one-cycle access); ext read data 1 cycle later; losing CPU sees cpu_stall.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  arb_state_t        state_q;
  logic              at_max;
  logic              ext_win;
  logic              cpu_win;
  logic              sel;
  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_wdata;
  logic              mux_we;

  // A lock shuts the CPU out entirely; otherwise ext only beats a requesting CPU once starved.
  always_comb begin
    ext_win = 1'b0;
    cpu_win = 1'b0;
    if (state_q == S_LOCKED) begin
      ext_win = bus.ext_req;
    end else begin
      ext_win = bus.ext_req & (~bus.cpu_req | at_max);
      cpu_win = bus.cpu_req & ~ext_win;
    end
  end

  assign sel = ext_win ? PORT_EXT : PORT_CPU;

  always_comb begin
    mux_addr  = bus.cpu_addr;
    mux_wdata = bus.cpu_wdata;
    mux_we    = bus.cpu_we & cpu_win;
    if (sel == PORT_EXT) begin
      mux_addr  = bus.ext_addr;
      mux_wdata = bus.ext_wdata;
      mux_we    = bus.ext_we & ext_win;
    end
  end

  assign bus.mem_addr  = mux_addr;
  assign bus.mem_wdata = mux_wdata;
  assign bus.mem_we    = mux_we;
  assign bus.cpu_gnt   = cpu_win;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_win;
  assign bus.ext_gnt   = ext_win;

  starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (bus.ext_req & ~ext_win),
    .clr    (ext_win | ~bus.ext_req),
    .at_max (at_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ext_rdata  <= '0;
      bus.ext_rvalid <= 1'b0;
    end else begin
      bus.ext_rvalid <= ext_win & ~bus.ext_we;
      if (ext_win && !bus.ext_we) begin
        bus.ext_rdata <= bus.mem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_LOCK_EN
  arb_state_t state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OPEN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OPEN:   if (ext_win && bus.ext_lock) state_d = S_LOCKED;
      S_LOCKED: if (!bus.ext_lock || !bus.ext_req) state_d = S_OPEN;
      default:  state_d = S_OPEN;
    endcase
  end
`else
  // Lock port kept so the interface is identical in both builds.
  logic unused_lock;
  assign unused_lock = bus.ext_lock;
  assign state_q     = S_OPEN;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256x8 data memory.
module tb_dmem_arbiter;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  dmem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_WAIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem [0:255];

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       cr;
    logic       cw;
    logic [7:0] ca;
    logic [7:0] cd;
    logic       er;
    logic       ew;
    logic [7:0] ea;
    logic [7:0] ed;
    logic       x_cpu;
    logic       x_stall;
    logic       x_ext;
    logic       x_we;
    logic [7:0] x_addr;
    logic [7:0] x_wd;
  } vec_t;

  vec_t vt [7];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_gnt(input string nm, input logic c, input logic s, input logic e);
    chk1({nm, ".cpu_gnt"}, bus.cpu_gnt, c);
    chk1({nm, ".cpu_stall"}, bus.cpu_stall, s);
    chk1({nm, ".ext_gnt"}, bus.ext_gnt, e);
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                       input logic er, input logic ew, input logic [7:0] ea, input logic [7:0] ed,
                       input logic el);
    bus.cpu_req   = cr;
    bus.cpu_we    = cw;
    bus.cpu_addr  = ca;
    bus.cpu_wdata = cd;
    bus.ext_req   = er;
    bus.ext_we    = ew;
    bus.ext_addr  = ea;
    bus.ext_wdata = ed;
    bus.ext_lock  = el;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    logic won;
    logic xe;
    n_chk  = 0;
    n_fail = 0;
    drive(F, F, 8'h00, 8'h00, F, F, 8'h00, 8'h00, F);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst.ext_rvalid", bus.ext_rvalid, F);
    chk8("rst.ext_rdata", bus.ext_rdata, 8'h00);
    chk_gnt("rst", F, F, F);
    chk1("rst.mem_we", bus.mem_we, F);
    rst_n = 1'b1;

    vt[0] = '{T, T, 8'h10, 8'hA5, F, F, 8'h00, 8'h00, T, F, F, T, 8'h10, 8'hA5};
    vt[1] = '{T, F, 8'h20, 8'h33, F, F, 8'h00, 8'h00, T, F, F, F, 8'h20, 8'h33};
    vt[2] = '{F, F, 8'h44, 8'h55, T, T, 8'h30, 8'h5A, F, F, T, T, 8'h30, 8'h5A};
    vt[3] = '{F, F, 8'h07, 8'h08, F, F, 8'h99, 8'h00, F, F, F, F, 8'h07, 8'h08};
    vt[4] = '{F, T, 8'h11, 8'h22, F, T, 8'h99, 8'h66, F, F, F, F, 8'h11, 8'h22};
    vt[5] = '{T, T, 8'h40, 8'h77, T, T, 8'h41, 8'h88, T, F, F, T, 8'h40, 8'h77};
    vt[6] = '{F, F, 8'h12, 8'h34, F, T, 8'h41, 8'h88, F, F, F, F, 8'h12, 8'h34};

    for (int i = 0; i < 7; i++) begin
      drive(vt[i].cr, vt[i].cw, vt[i].ca, vt[i].cd, vt[i].er, vt[i].ew, vt[i].ea, vt[i].ed, F);
      @(negedge clk);
      chk_gnt($sformatf("vec%0d", i), vt[i].x_cpu, vt[i].x_stall, vt[i].x_ext);
      chk1($sformatf("vec%0d.mem_we", i), bus.mem_we, vt[i].x_we);
      chk8($sformatf("vec%0d.mem_addr", i), bus.mem_addr, vt[i].x_addr);
      chk8($sformatf("vec%0d.mem_wdata", i), bus.mem_wdata, vt[i].x_wd);
      next_cycle();
    end
    chk8("mem10", mem[8'h10], 8'hA5);
    chk8("mem30", mem[8'h30], 8'h5A);
    chk8("mem40", mem[8'h40], 8'h77);
    chk8("mem41_dropped", mem[8'h41], 8'h00);

    // External read, one-cycle rvalid pulse
    drive(F, F, 8'h00, 8'h00, T, F, 8'h10, 8'h00, F);
    @(negedge clk);
    chk_gnt("rd", F, F, T);
    chk1("rd.mem_we", bus.mem_we, F);
    next_cycle();
    drive(F, F, 8'h00, 8'h00, F, F, 8'h00, 8'h00, F);
    chk1("rd.rvalid1", bus.ext_rvalid, T);
    chk8("rd.rdata", bus.ext_rdata, 8'hA5);
    next_cycle();
    chk1("rd.rvalid0", bus.ext_rvalid, F);

    // Ext write loses three times then withdraws: no write, counter cleared
    drive(T, F, 8'h20, 8'h00, T, T, 8'h50, 8'hEE, F);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_gnt($sformatf("drop_c%0d", c), T, F, F);
      next_cycle();
    end
    drive(F, F, 8'h00, 8'h00, F, T, 8'h50, 8'hEE, F);
    next_cycle();
    chk8("mem50_dropped", mem[8'h50], 8'h00);

    // Both held: 4 CPU grants then one ext grant, repeating
    drive(T, F, 8'h20, 8'h00, T, F, 8'h10, 8'h00, F);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      xe = (c % 5 == 4);
      chk_gnt($sformatf("starve_c%0d", c), ~xe, xe, xe);
      next_cycle();
    end

    // Async reset with wait count at 3 restarts the starvation window
    drive(F, F, 8'h00, 8'h00, F, F, 8'h00, 8'h00, F);
    next_cycle();
    drive(T, F, 8'h20, 8'h00, T, F, 8'h10, 8'h00, F);
    repeat (3) next_cycle();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      xe = (c == 4);
      chk_gnt($sformatf("rstw_c%0d", c), ~xe, xe, xe);
      next_cycle();
    end

    // Async reset kills a pending rvalid
    drive(F, F, 8'h00, 8'h00, T, F, 8'h10, 8'h00, F);
    next_cycle();
    drive(F, F, 8'h00, 8'h00, F, F, 8'h00, 8'h00, F);
    chk1("rstv.rvalid_before", bus.ext_rvalid, T);
    rst_n = 1'b0;
    #1;
    chk1("rstv.rvalid_after", bus.ext_rvalid, F);
    chk8("rstv.rdata_after", bus.ext_rdata, 8'h00);
    rst_n = 1'b1;
    next_cycle();

    // Lock request during CPU traffic
    drive(T, F, 8'h20, 8'h00, T, F, 8'h10, 8'h00, T);
    won = F;
    cyc = 0;
    for (int i = 0; i < 8 && !won; i++) begin
      @(negedge clk);
      if (bus.ext_gnt) begin
        won = T;
        cyc = i;
      end else begin
        next_cycle();
      end
    end
    chk1("lock.won", won, T);
    chk8("lock.win_cycle", 8'(cyc), 8'd4);
    if (won) next_cycle();
`ifdef DMEM_ARB_LOCK_EN
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk_gnt($sformatf("lock_hold%0d", k), F, T, T);
      next_cycle();
    end
    drive(T, F, 8'h20, 8'h00, F, F, 8'h10, 8'h00, F);
    @(negedge clk);
    chk_gnt("lock_release", F, T, F);
    next_cycle();
    @(negedge clk);
    chk_gnt("lock_after", T, F, F);
    next_cycle();

    // Reset while locked returns to open arbitration
    drive(F, F, 8'h00, 8'h00, T, F, 8'h10, 8'h00, T);
    next_cycle();
    drive(T, F, 8'h20, 8'h00, T, F, 8'h10, 8'h00, T);
    chk_gnt("lockrst.before", F, T, T);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    chk_gnt("lockrst.after", T, F, F);
    next_cycle();
`else
    @(negedge clk);
    chk_gnt("nolock_after", T, F, F);
    next_cycle();
`endif
    drive(F, F, 8'h00, 8'h00, F, F, 8'h00, 8'h00, F);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
